// File: rtl/operand2_fetch_pkg.sv
// operand2_fetch_pkg: shared encodings, FSM states and Operand2 field positions.
// Operand2 is numbered [12:1], so every field position below is one-based.
package operand2_fetch_pkg;
    typedef enum logic [2:0] {IDLE, RD_RM, CAP_RM, CAP_RS, DONE} state_t;
    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;
    // SHIFT_OP[1]: 1 = register-specified amount or pass-on-zero, 0 = immediate amount
    localparam logic SHOP_REG = 1'b1;
    localparam logic SHOP_IMM = 1'b0;
    localparam int RM_HI    = 4;
    localparam int RM_LO    = 1;
    localparam int REGSH    = 5;
    localparam int TYPE_HI  = 7;
    localparam int TYPE_LO  = 6;
    localparam int SHIMM_HI = 12;
    localparam int SHIMM_LO = 8;
    localparam int RS_HI    = 12;
    localparam int RS_LO    = 9;
    localparam int ROT_HI   = 12;
    localparam int ROT_LO   = 9;
    localparam int IMM8_HI  = 8;
    localparam int IMM8_LO  = 1;
endpackage

// File: rtl/operand2_fetch_if.sv
// operand2_fetch_if: request, register-file read and shifter-operand signals of operand2_fetch.
interface operand2_fetch_if;
    logic        Start;
    logic        I_bit;
    logic [12:1] Operand2;
    logic        Rd_En;
    logic [3:0]  Rd_Addr;
    logic [31:0] Rd_Data;
    logic [31:0] Shift_Data;
    logic [7:0]  Shift_Num;
    logic [3:1]  SHIFT_OP;
    logic        Busy;
    logic        Done;
    modport master (
        output Start, I_bit, Operand2, Rd_Data,
        input  Rd_En, Rd_Addr, Shift_Data, Shift_Num, SHIFT_OP, Busy, Done
    );
    modport slave (
        input  Start, I_bit, Operand2, Rd_Data,
        output Rd_En, Rd_Addr, Shift_Data, Shift_Num, SHIFT_OP, Busy, Done
    );
endinterface

// File: rtl/operand2_fetch_op2_field_decode.sv
// op2_field_decode: splits an ARM data-processing Operand2 field into its sub-fields.
module op2_field_decode
    import operand2_fetch_pkg::*;
(
    input  logic [12:1] op2,
    output logic [3:0]  rm,
    output logic [3:0]  rs,
    output logic [1:0]  sh_type,
    output logic        reg_shift,
    output logic [4:0]  shift_imm,
    output logic [3:0]  rot,
    output logic [7:0]  imm8
);
    assign rm        = op2[RM_HI:RM_LO];
    assign rs        = op2[RS_HI:RS_LO];
    assign sh_type   = op2[TYPE_HI:TYPE_LO];
    assign reg_shift = op2[REGSH];
    assign shift_imm = op2[SHIMM_HI:SHIMM_LO];
    assign rot       = op2[ROT_HI:ROT_LO];
    assign imm8      = op2[IMM8_HI:IMM8_LO];
endmodule

// File: rtl/operand2_fetch.sv
// operand2_fetch: fetches the shifter operands (data, amount, type) for an ARM Operand2 field,
// reading Rm and optionally Rs from the register file.
module operand2_fetch
    import operand2_fetch_pkg::*;
(
    input logic clk,
    input logic rst,
    operand2_fetch_if.slave bus
);
    state_t      state, next;
    logic [12:1] op2_q;
    logic [12:1] op2;
    logic        accept;
    logic [3:0]  rm, rs, rot;
    logic [1:0]  sh_type;
    logic        reg_shift;
    logic [4:0]  shift_imm;
    logic [7:0]  imm8;

    assign accept = bus.Start && (state == IDLE || state == DONE);
    // Decode the live field on the accepting edge, the latched copy otherwise
    assign op2 = accept ? bus.Operand2 : op2_q;

    op2_field_decode u_dec (
        .op2       (op2),
        .rm        (rm),
        .rs        (rs),
        .sh_type   (sh_type),
        .reg_shift (reg_shift),
        .shift_imm (shift_imm),
        .rot       (rot),
        .imm8      (imm8)
    );

    always_ff @(posedge clk)
        state <= rst ? IDLE : next;

    always_comb
        next = state == RD_RM  ? CAP_RM :
               state == CAP_RM ? (reg_shift ? CAP_RS : DONE) :
               state == CAP_RS ? DONE :
               accept          ? (bus.I_bit ? DONE : RD_RM) : IDLE;

    always_comb begin
        bus.Busy    = state inside {RD_RM, CAP_RM, CAP_RS};
        bus.Done    = state == DONE;
        bus.Rd_En   = state == RD_RM || (state == CAP_RM && reg_shift);
        bus.Rd_Addr = state == RD_RM ? rm : (state == CAP_RM && reg_shift) ? rs : 4'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op2_q          <= '0;
            bus.Shift_Data <= '0;
            bus.Shift_Num  <= '0;
            bus.SHIFT_OP   <= '0;
        end else if (accept) begin
            op2_q <= bus.Operand2;
            if (bus.I_bit) begin
                bus.Shift_Data <= {24'b0, imm8};
                bus.SHIFT_OP   <= {SH_ROR, SHOP_REG};
                bus.Shift_Num  <= {3'b0, rot, 1'b0};
            end
        end else if (state == CAP_RM) begin
            bus.Shift_Data <= bus.Rd_Data;
            if (!reg_shift) begin
                bus.SHIFT_OP  <= {sh_type, SHOP_IMM};
                bus.Shift_Num <= {3'b0, shift_imm};
            end
        end else if (state == CAP_RS) begin
            bus.Shift_Num <= bus.Rd_Data[7:0];
            bus.SHIFT_OP  <= {sh_type, SHOP_REG};
        end
    end
endmodule

// File: tb/tb_operand2_fetch.sv
// tb_operand2_fetch: directed vector table plus reset and back-to-back sequences for operand2_fetch.
module tb_operand2_fetch;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] rf [16];

    operand2_fetch_if bus ();
    operand2_fetch dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Register file: data appears the cycle after the read strobe
    always @(posedge clk)
        bus.Rd_Data <= bus.Rd_En ? rf[bus.Rd_Addr] : 32'h0BAD_0BAD;

    typedef struct packed {
        logic        i_bit;
        logic [11:0] op2;
        logic [3:0]  lat;
        logic [1:0]  reads;
        logic [3:0]  a1;
        logic [3:0]  a2;
        logic [31:0] data;
        logic [2:0]  op;
        logic [7:0]  num;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run(input int idx, input vec_t v);
        int cyc;
        int reads;
        logic [3:0] a1, a2;
        bus.I_bit = v.i_bit;
        bus.Operand2 = v.op2;
        bus.Start = 1'b1;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        cyc = 1; reads = 0; a1 = '0; a2 = '0;
        while (!bus.Done && cyc < 8) begin
            chk($sformatf("v%0d busy", idx), 32'(bus.Busy), 32'd1);
            if (bus.Rd_En) begin
                reads++;
                if (cyc == 1) a1 = bus.Rd_Addr; else a2 = bus.Rd_Addr;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk($sformatf("v%0d latency", idx), 32'(cyc), 32'(v.lat));
        chk($sformatf("v%0d reads", idx), 32'(reads), 32'(v.reads));
        if (v.reads > 0) chk($sformatf("v%0d rm_addr", idx), 32'(a1), 32'(v.a1));
        if (v.reads > 1) chk($sformatf("v%0d rs_addr", idx), 32'(a2), 32'(v.a2));
        chk($sformatf("v%0d shift_data", idx), bus.Shift_Data, v.data);
        chk($sformatf("v%0d shift_op", idx), 32'(bus.SHIFT_OP), 32'(v.op));
        chk($sformatf("v%0d shift_num", idx), 32'(bus.Shift_Num), 32'(v.num));
        @(posedge clk); #1;
        chk($sformatf("v%0d done_drop", idx), 32'({bus.Done, bus.Busy}), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] dones;
        int cnt;
        for (int i = 0; i < 16; i++) rf[i] = 32'h1000_0000 + 32'(i);
        rf[0] = 32'h1234_5678;
        rf[3] = 32'h8000_0000;
        rf[4] = 32'h0000_0123;
        rf[5] = 32'hCAFE_F00D;
        rf[7] = 32'hDEAD_BEEF;
        //          i  op2      lat reads a1 a2  data            op      num
        vecs[0] = '{1'b1, 12'h4FF, 4'd1, 2'd0, 4'd0, 4'd0, 32'h0000_00FF, 3'b111, 8'd8};
        vecs[1] = '{1'b0, 12'h2A3, 4'd3, 2'd1, 4'd3, 4'd0, 32'h8000_0000, 3'b010, 8'd5};
        vecs[2] = '{1'b0, 12'h477, 4'd4, 2'd2, 4'd7, 4'd4, 32'hDEAD_BEEF, 3'b111, 8'h23};
        vecs[3] = '{1'b0, 12'h060, 4'd3, 2'd1, 4'd0, 4'd0, 32'h1234_5678, 3'b110, 8'd0};
        vecs[4] = '{1'b0, 12'h494, 4'd4, 2'd2, 4'd4, 4'd4, 32'h0000_0123, 3'b001, 8'h23};
        vecs[5] = '{1'b0, 12'h025, 4'd3, 2'd1, 4'd5, 4'd0, 32'hCAFE_F00D, 3'b010, 8'd0};
        vecs[6] = '{1'b1, 12'hF01, 4'd1, 2'd0, 4'd0, 4'd0, 32'h0000_0001, 3'b111, 8'd30};
        vecs[7] = '{1'b0, 12'hFC3, 4'd3, 2'd1, 4'd3, 4'd0, 32'h8000_0000, 3'b100, 8'd31};

        rst = 1'b1; bus.Start = 1'b0; bus.I_bit = 1'b0; bus.Operand2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", {bus.Shift_Data[15:0], bus.Shift_Num, bus.SHIFT_OP, bus.Rd_Addr, bus.Rd_En}, 32'd0);
        chk("reset data", bus.Shift_Data, 32'd0);
        chk("reset status", 32'({bus.Busy, bus.Done}), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run(i, vecs[i]);

        // Reset in CAP_RM with a Start pulse ignored while busy
        bus.I_bit = 1'b0; bus.Operand2 = 12'h477; bus.Start = 1'b1;
        @(posedge clk); #1;
        bus.I_bit = 1'b1; bus.Operand2 = 12'h4FF;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        chk("ignored start busy", 32'(bus.Busy), 32'd1);
        chk("ignored start rs_addr", 32'(bus.Rd_Addr), 32'd4);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort outputs", {bus.Shift_Data[15:0], bus.Shift_Num, bus.SHIFT_OP, bus.Rd_Addr, bus.Rd_En}, 32'd0);
        chk("abort status", 32'({bus.Busy, bus.Done}), 32'd0);
        cnt = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.Done) cnt++;
        end
        chk("abort no done", 32'(cnt), 32'd0);
        chk("abort data ignored", bus.Shift_Data, 32'd0);

        // Back-to-back fetches with Start held through DONE
        bus.I_bit = 1'b0; bus.Operand2 = 12'h2A3; bus.Start = 1'b1;
        dones = '0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            dones[c-1] = bus.Done;
            if (c == 3) begin
                chk("b2b first data", bus.Shift_Data, 32'h8000_0000);
                bus.Operand2 = 12'h025;
            end
            if (c == 4) chk("b2b no idle", 32'(bus.Busy), 32'd1);
            if (c == 6) bus.Start = 1'b0;
        end
        chk("b2b done pattern", 32'(dones), 32'b100100);
        chk("b2b second data", bus.Shift_Data, 32'hCAFE_F00D);
        chk("b2b second op", 32'({bus.SHIFT_OP, bus.Shift_Num}), 32'({3'b010, 8'd0}));
        @(posedge clk); #1;
        chk("b2b idle", 32'({bus.Done, bus.Busy}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
